// File: rtl/serial_deser_pkg.sv
// rtl/serial_deser_pkg.sv - shared types and frame-format constants for serial_deser
// Frame length depends on SERIAL_DESER_PARITY_EN (adds one even-parity bit per byte).
package serial_deser_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
    localparam int DATA_BITS = 8;
`ifdef SERIAL_DESER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_BITS = DATA_BITS + PARITY_BITS;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - sync-word hunting serial-to-byte deserializer
// Optional even parity per byte selected by SERIAL_DESER_PARITY_EN.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_in,
    input  logic       bit_en,
    input  logic       flush,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sync_found,
    output logic       locked,
    output logic [7:0] frame_cnt,
    output logic       parity_err
);

    localparam int             DW       = FRAME_BITS - 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(8);

    state_t           state;
    // Only the last seven hunt bits need storage; the incoming bit completes the window.
    logic [6:0]       shreg;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [DW-1:0]    dreg;

    logic [7:0] hunt_window;
    logic [7:0] byte_next;
    logic       par_bad;
    logic       last_bit;

    assign hunt_window = {shreg, d_in};
    assign last_bit    = (bit_cnt == LAST_BIT);

`ifdef SERIAL_DESER_PARITY_EN
    assign byte_next = dreg;
    assign par_bad   = ^{dreg, d_in};
`else
    assign byte_next = {dreg, d_in};
    assign par_bad   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= HUNT;
            shreg      <= '0;
            fill_cnt   <= '0;
            bit_cnt    <= '0;
            dreg       <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            sync_found <= 1'b0;
            locked     <= 1'b0;
            frame_cnt  <= 8'h00;
            parity_err <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sync_found <= 1'b0;
            parity_err <= 1'b0;
            if (flush) begin
                state    <= HUNT;
                locked   <= 1'b0;
                shreg    <= '0;
                fill_cnt <= '0;
                bit_cnt  <= '0;
                dreg     <= '0;
            end else if (bit_en) begin
                if (state == HUNT) begin
                    shreg <= hunt_window[6:0];
                    if (fill_cnt < FILL_MAX) begin
                        fill_cnt <= fill_cnt + CNT_W'(1);
                    end
                    // fill_cnt >= 7 means this bit is at least the eighth since entering HUNT.
                    if ((fill_cnt >= CNT_W'(7)) && (hunt_window == SYNC_WORD)) begin
                        state      <= LOCK;
                        locked     <= 1'b1;
                        sync_found <= 1'b1;
                        bit_cnt    <= '0;
                    end
                end else begin
                    dreg <= {dreg[DW-2:0], d_in};
                    if (last_bit) begin
                        bit_cnt    <= '0;
                        data_out   <= byte_next;
                        data_valid <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                        if (par_bad) begin
                            parity_err <= 1'b1;
                            state      <= HUNT;
                            locked     <= 1'b0;
                            shreg      <= '0;
                            fill_cnt   <= '0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_deser.sv
// tb/tb_serial_deser.sv - scoreboard bench for serial_deser against a queue-based frame model
// Honours SERIAL_DESER_PARITY_EN through serial_deser_pkg::FRAME_BITS.
module tb_serial_deser;
    import serial_deser_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_in = 1'b0;
    logic       bit_en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] data_out, frame_cnt, data_out0, frame_cnt0;
    logic       data_valid, sync_found, locked, parity_err;
    logic       data_valid0, sync_found0, locked0, parity_err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_deser #(.SYNC_WORD(8'hA5)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .bit_en(bit_en), .flush(flush),
        .data_out(data_out), .data_valid(data_valid), .sync_found(sync_found),
        .locked(locked), .frame_cnt(frame_cnt), .parity_err(parity_err)
    );

    serial_deser #(.SYNC_WORD(8'h00)) dut0 (
        .clk(clk), .rst(rst), .d_in(d_in), .bit_en(bit_en), .flush(flush),
        .data_out(data_out0), .data_valid(data_valid0), .sync_found(sync_found0),
        .locked(locked0), .frame_cnt(frame_cnt0), .parity_err(parity_err0)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] cnt;
        logic       perr;
    } exp_t;

    exp_t       exp_q[$];
    bit         hunt_bits[$];
    bit         lock_bits[$];
    bit         m_locked = 1'b0;
    bit         m_perr;
    int         m_frames = 0;
    int         m_syncs = 0;
    int         m_ones;
    logic [7:0] m_word;
    int         dut_syncs = 0;
    int         dut0_syncs = 0;
    int         dv_count = 0;
    exp_t       e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bit lists since entering HUNT / since LOCK, evaluated per accepted bit.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hunt_bits.delete();
            lock_bits.delete();
            m_locked = 1'b0;
            m_frames = 0;
        end else if (flush) begin
            hunt_bits.delete();
            lock_bits.delete();
            m_locked = 1'b0;
        end else if (bit_en) begin
            if (!m_locked) begin
                hunt_bits.push_back(d_in);
                if (hunt_bits.size() > 8) void'(hunt_bits.pop_front());
                if (hunt_bits.size() == 8) begin
                    m_word = 8'h00;
                    foreach (hunt_bits[i]) m_word = {m_word[6:0], hunt_bits[i]};
                    if (m_word == 8'hA5) begin
                        m_locked = 1'b1;
                        m_syncs++;
                        lock_bits.delete();
                    end
                end
            end else begin
                lock_bits.push_back(d_in);
                if (lock_bits.size() == FRAME_BITS) begin
                    m_word = 8'h00;
                    m_ones = 0;
                    for (int i = 0; i < 8; i++) m_word = {m_word[6:0], lock_bits[i]};
                    foreach (lock_bits[i]) m_ones += int'(lock_bits[i]);
                    m_perr = (FRAME_BITS == 9) && (m_ones % 2 != 0);
                    m_frames++;
                    exp_q.push_back('{m_word, 8'(m_frames), m_perr});
                    lock_bits.delete();
                    if (m_perr) begin
                        m_locked = 1'b0;
                        hunt_bits.delete();
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte.
    always @(negedge clk) begin
        if (rst) begin
            check("locked", 32'(locked), 32'(m_locked));
            if (sync_found) dut_syncs++;
            if (sync_found0) dut0_syncs++;
            if (data_valid) begin
                dv_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(data_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(e.data));
                    check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
                    check("parity_err", 32'(parity_err), 32'(e.perr));
                end
            end else begin
                check("parity_err_alone", 32'(parity_err), 32'd0);
            end
        end
    end

    task automatic drive(input bit b, input bit en, input bit fl);
        @(negedge clk);
        d_in   = b;
        bit_en = en;
        flush  = fl;
    endtask

    task automatic settle();
        drive(1'($urandom), 1'b0, 1'b0);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input int gap);
        logic [7:0] w;
        w = v;
        for (int i = 7; i >= 8 - n; i--) begin
            drive(w[i], 1'b1, 1'b0);
            repeat (gap) drive(1'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap, input bit bad_par);
        send_bits(v, 8, gap);
        if (FRAME_BITS == 9) begin
            drive((^v) ^ bad_par, 1'b1, 1'b0);
            repeat (gap) drive(1'($urandom), 1'b0, 1'b0);
        end
    endtask

    int  dv_before;
    int  r;
    bit  bad;

    initial begin
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            d_in   = 1'($urandom);
            bit_en = 1'($urandom);
        end
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_sync_found", 32'(sync_found), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst0_outputs", 32'({data_out0, frame_cnt0, data_valid0, sync_found0, locked0, parity_err0}), 32'd0);
        @(negedge clk);
        bit_en = 1'b0;
        rst    = 1'b1;

        // Fill rule on the all-zero sync word: seven zeros must not match.
        repeat (7) drive(1'b0, 1'b1, 1'b0);
        settle();
        check("zero_sync_partial", 32'(dut0_syncs), 32'd0);
        check("zero_sync_partial_locked", 32'(locked0), 32'd0);
        drive(1'b0, 1'b1, 1'b0);
        settle();
        check("zero_sync_full", 32'(dut0_syncs), 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        settle();

        // Sync then 8'h3C back-to-back.
        send_bits(8'hA5, 8, 0);
        settle();
        check("sync_pulse", 32'(sync_found), 32'd1);
        check("sync_count", 32'(dut_syncs), 32'd1);
        send_byte(8'h3C, 0, 1'b0);
        settle();
        check("byte1_valid", 32'(data_valid), 32'd1);
        check("byte1_data", 32'(data_out), 32'h3C);
        check("byte1_cnt", 32'(frame_cnt), 32'd1);
        settle();
        check("byte1_valid_single", 32'(data_valid), 32'd0);

        // Gapped byte after a fresh sync.
        drive(1'b0, 1'b0, 1'b1);
        send_bits(8'hA5, 8, 0);
        dv_before = dv_count;
        send_byte(8'hC3, 2, 1'b0);
        settle();
        check("gap_valid_count", 32'(dv_count - dv_before), 32'd1);
        check("gap_data", 32'(data_out), 32'hC3);
        check("gap_cnt", 32'(frame_cnt), 32'd2);

        // Flush mid-byte with a coincident bit.
        dv_before = dv_count;
        send_bits(8'hF0, 4, 0);
        drive(1'b1, 1'b1, 1'b1);
        settle();
        check("flush_locked", 32'(locked), 32'd0);
        check("flush_no_valid", 32'(dv_count - dv_before), 32'd0);
        check("flush_data_kept", 32'(data_out), 32'hC3);
        check("flush_cnt_kept", 32'(frame_cnt), 32'd2);
        send_bits(8'hA5, 7, 0);
        settle();
        check("relock_partial", 32'(locked), 32'd0);
        drive(1'b1, 1'b1, 1'b0);
        settle();
        check("relock_full", 32'(locked), 32'd1);

        // Random traffic until 256 bytes have been delivered since reset.
        while (m_frames < 256) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                send_bits(8'($urandom), int'($urandom_range(1, 7)), 0);
                drive(1'($urandom), 1'b1, 1'b1);
                send_bits(8'hA5, 8, int'($urandom_range(0, 1)));
            end else begin
                bad = (FRAME_BITS == 9) && (r == 1);
                send_byte(8'($urandom), int'($urandom_range(0, 1)), bad);
                if (bad) send_bits(8'hA5, 8, 0);
            end
            drive(1'b0, 1'b0, 1'b0);
        end
        settle();
        check("wrap_frames", 32'(m_frames), 32'd256);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

`ifdef SERIAL_DESER_PARITY_EN
        drive(1'b0, 1'b0, 1'b1);
        send_bits(8'hA5, 8, 0);
        send_bits(8'h81, 8, 0);
        drive(1'b1, 1'b1, 1'b0);
        settle();
        check("par_valid", 32'(data_valid), 32'd1);
        check("par_err", 32'(parity_err), 32'd1);
        check("par_data", 32'(data_out), 32'h81);
        check("par_locked", 32'(locked), 32'd0);
`endif

        repeat (2) settle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("sync_total", 32'(dut_syncs), 32'(m_syncs));
        check("valid_total", 32'(dv_count), 32'(m_frames));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
